pending_encoder_8x3: RTL and testbench

//  Reverse of the 3x8 decoder: collects rising edges on 8 one-hot-ish request lines into a

---
 rtl/pending_encoder_8x3_if.sv | 11 +
 rtl/pending_encoder_8x3.sv | 116 +++++++++++
 tb/tb_pending_encoder_8x3.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pending_encoder_8x3_if.sv
// Valid/ready handshake carrying the encoded request index from the encoder to its consumer.
interface pending_encoder_8x3_if #(
  parameter int W = 3
);
  logic [W-1:0] out_code;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_code, output out_valid, input out_ready);
  modport slave  (input out_code, input out_valid, output out_ready);
endinterface

// File: rtl/pending_encoder_8x3.sv
// Captures rising edges on 8 request lines into a sticky pending set and hands them out,
// one priority-ordered 3-bit code per accepted valid/ready handshake.
module pending_encoder_8x3 #(
  parameter int N             = 8,
  parameter int W             = 3,
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [N-1:0]          req,
  pending_encoder_8x3_if.master bus,
  output logic [N-1:0]          pending,
  output logic                  overflow
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] req_q, req_d;
  logic [N-1:0] pending_q, pending_d;
  logic         overflow_q, overflow_d;
  logic [W-1:0] code_q, code_d;
  logic         valid_q, valid_d;

  logic [N-1:0] rise_s;
  logic [N-1:0] clr_s;
  logic [N-1:0] nxt_avail_s;
  logic         accept_s;

  function automatic logic [W-1:0] pick(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) idx = W'(i);
        else      idx = idx;
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (v[i]) idx = W'(i);
        else      idx = idx;
      end
    end
    return idx;
  endfunction

  // Edge detect, pending/overflow update and the IDLE/PRESENT handshake FSM.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    valid_d    = valid_q;
    req_d      = req;
    rise_s     = req & ~req_q;
    accept_s   = valid_q && bus.out_ready;
    if (accept_s) clr_s = N'(1) << code_q;
    else          clr_s = '0;
    nxt_avail_s = pending_q & ~clr_s;
    if (enable) pending_d = nxt_avail_s | rise_s;
    else        pending_d = nxt_avail_s;
    // A new edge on a bit that survives this cycle's clear is a lost event.
    overflow_d = overflow_q | (enable && (|(rise_s & nxt_avail_s)));

    case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          code_d  = pick(pending_q);
          valid_d = 1'b1;
          state_d = PRESENT;
        end else begin
          valid_d = 1'b0;
        end
      end
      PRESENT: begin
        if (accept_s) begin
          if (nxt_avail_s != '0) begin
            code_d = pick(nxt_avail_s);
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; req_q still tracks req during reset.
  always_ff @(posedge clk) begin
    req_q <= req_d;
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      code_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.out_code  = code_q;
  assign bus.out_valid = valid_q;
  assign pending       = pending_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_pending_encoder_8x3.sv
// Drives both priority variants with shared stimulus; a reference model queues expected
// post-edge snapshots and a monitor process compares them against the DUTs.
module tb_pending_encoder_8x3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] req = 8'h00;

  logic [7:0] pending_hi, pending_lo;
  logic       overflow_hi, overflow_lo;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pending_encoder_8x3_if #(.W(3)) bus_hi ();
  pending_encoder_8x3_if #(.W(3)) bus_lo ();
  assign bus_hi.out_ready = out_ready;
  assign bus_lo.out_ready = out_ready;

  pending_encoder_8x3 #(.N(8), .W(3), .PRIORITY_HIGH(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .bus(bus_hi),
    .pending(pending_hi), .overflow(overflow_hi)
  );

  pending_encoder_8x3 #(.N(8), .W(3), .PRIORITY_HIGH(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .bus(bus_lo),
    .pending(pending_lo), .overflow(overflow_lo)
  );

  typedef struct packed {
    logic [7:0] pend;
    logic [2:0] code;
    logic       valid;
    logic       ovf;
  } snap_t;

  snap_t q_hi[$];
  snap_t q_lo[$];

  // Reference model: events as a set of pending indices, one presented code per variant.
  bit   m_pend [2][8];
  int   m_code [2];
  bit   m_valid[2];
  bit   m_ovf  [2];
  bit   m_prev [8];

  function automatic int choose(input int p, input bit s[8]);
    int best = -1;
    for (int i = 0; i < 8; i++)
      if (s[i]) begin
        if (best < 0) best = i;
        else if (p == 0 && i > best) best = i;
      end
    return best;
  endfunction

  function automatic snap_t snap(input int p);
    snap_t s;
    s.pend = 8'h00;
    for (int i = 0; i < 8; i++) s.pend[i] = m_pend[p][i];
    s.code  = 3'(m_code[p]);
    s.valid = m_valid[p];
    s.ovf   = m_ovf[p];
    return s;
  endfunction

  task automatic model_step(input bit r, input bit e, input logic [7:0] rq, input bit rd);
    for (int p = 0; p < 2; p++) begin
      if (r) begin
        for (int i = 0; i < 8; i++) m_pend[p][i] = 1'b0;
        m_code[p] = 0; m_valid[p] = 1'b0; m_ovf[p] = 1'b0;
      end else begin
        bit avail[8];
        bit acc;
        int c;
        acc = m_valid[p] && rd;
        for (int i = 0; i < 8; i++)
          avail[i] = m_pend[p][i] && !(acc && m_code[p] == i);
        for (int i = 0; i < 8; i++)
          if (e && rq[i] && !m_prev[i] && avail[i]) m_ovf[p] = 1'b1;
        if (!m_valid[p]) begin
          c = choose(p, m_pend[p]);
          if (c >= 0) begin m_code[p] = c; m_valid[p] = 1'b1; end
        end else if (acc) begin
          c = choose(p, avail);
          if (c >= 0) m_code[p] = c;
          else        m_valid[p] = 1'b0;
        end
        for (int i = 0; i < 8; i++)
          m_pend[p][i] = avail[i] || (e && rq[i] && !m_prev[i]);
      end
    end
    for (int i = 0; i < 8; i++) m_prev[i] = rq[i];
    q_hi.push_back(snap(0));
    q_lo.push_back(snap(1));
  endtask

  task automatic cycle(input bit r, input bit e, input logic [7:0] rq, input bit rd);
    @(negedge clk);
    rst = r; enable = e; req = rq; out_ready = rd;
    model_step(r, e, rq, rd);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: after each edge pop the expected snapshot and compare both variants.
  always @(posedge clk) begin
    #1;
    if (q_hi.size() > 0 && q_lo.size() > 0) begin
      snap_t eh, el;
      eh = q_hi.pop_front();
      el = q_lo.pop_front();
      check("hi_valid",    {7'd0, bus_hi.out_valid}, {7'd0, eh.valid});
      check("hi_code",     {5'd0, bus_hi.out_code},  {5'd0, eh.code});
      check("hi_pending",  pending_hi,               eh.pend);
      check("hi_overflow", {7'd0, overflow_hi},      {7'd0, eh.ovf});
      check("lo_valid",    {7'd0, bus_lo.out_valid}, {7'd0, el.valid});
      check("lo_code",     {5'd0, bus_lo.out_code},  {5'd0, el.code});
      check("lo_pending",  pending_lo,               el.pend);
      check("lo_overflow", {7'd0, overflow_lo},      {7'd0, el.ovf});
    end
  end

  initial begin
    // Reset with lines held high: no event after release.
    repeat (2) cycle(1'b1, 1'b1, 8'h81, 1'b1);
    repeat (4) cycle(1'b0, 1'b1, 8'h81, 1'b1);
    // Single request, immediate accept.
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    repeat (4) cycle(1'b0, 1'b1, 8'h08, 1'b1);
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    // Three simultaneous requests drained back-to-back in priority order.
    repeat (5) cycle(1'b0, 1'b1, 8'hA4, 1'b1);
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    // Stalled presentation is not preempted by a higher-priority arrival.
    repeat (6) cycle(1'b0, 1'b1, 8'h04, 1'b0);
    repeat (2) cycle(1'b0, 1'b1, 8'h44, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 8'h00, 1'b1);
    // Repeated edge on a pending, unaccepted bit sets overflow.
    cycle(1'b0, 1'b1, 8'h02, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h02, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 8'h00, 1'b1);
    // Edge coinciding with the accept of the same bit: re-pended, no overflow.
    cycle(1'b1, 1'b1, 8'h00, 1'b0);
    repeat (2) cycle(1'b0, 1'b1, 8'h02, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h02, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 8'h00, 1'b1);
    // Edges while disabled are lost, and a held line yields nothing later.
    repeat (3) cycle(1'b0, 1'b0, 8'h10, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 8'h10, 1'b1);
    // Reset in the middle of a presentation drops it.
    repeat (3) cycle(1'b0, 1'b1, 8'h11, 1'b0);
    cycle(1'b1, 1'b1, 8'h11, 1'b0);
    repeat (2) cycle(1'b0, 1'b1, 8'h00, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] nr;
      nr = req ^ (8'($urandom()) & 8'($urandom()) & 8'($urandom()));
      cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
            nr,
            ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
    end

    for (int n = 0; n < 10 && (q_hi.size() > 0 || q_lo.size() > 0); n++) @(negedge clk);
    check("queue_drained", 8'(q_hi.size() + q_lo.size()), 8'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
